// File: rtl/picomips_pkg.sv
// Shared definitions for the picoMIPS controller: FSM states, instruction
// field positions and opcode values (opcodes double as ALU function codes).
package picomips_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StExec2,
    StWb
  } state_e;

  // Instruction field positions within the 17-bit word.
  localparam int unsigned OpHi  = 16;
  localparam int unsigned OpLo  = 14;
  localparam int unsigned RdHi  = 13;
  localparam int unsigned RdLo  = 11;
  localparam int unsigned RsHi  = 10;
  localparam int unsigned RsLo  = 8;
  localparam int unsigned ImmHi = 7;
  localparam int unsigned ImmLo = 0;

  // Opcodes, numerically identical to the ALU function codes.
  localparam logic [2:0] RADD  = 3'd0;
  localparam logic [2:0] RADDI = 3'd1;
  localparam logic [2:0] RMUL  = 3'd2;
  localparam logic [2:0] RLD   = 3'd3;
  localparam logic [2:0] RBEQ  = 3'd4;
  localparam logic [2:0] RBNE  = 3'd5;

  function automatic logic is_defined(input logic [2:0] op);
    return (op == RADD) || (op == RADDI) || (op == RMUL) ||
           (op == RLD)  || (op == RBEQ)  || (op == RBNE);
  endfunction

  function automatic logic writes_reg(input logic [2:0] op);
    return (op == RLD) || (op == RADD) || (op == RADDI) || (op == RMUL);
  endfunction

  function automatic logic uses_imm(input logic [2:0] op);
    return (op == RADDI) || (op == RLD);
  endfunction

  // Undefined opcodes run as a NOP, which presents RADD to the ALU.
  function automatic logic [2:0] alu_func(input logic [2:0] op);
    return is_defined(op) ? op : RADD;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: holds, increments by one, or adds a signed 8-bit offset.
// Arithmetic wraps modulo 2^PW.
module pc_reg #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          step,
  input  logic          branch,
  input  logic [7:0]    offset,
  output logic [PW-1:0] pc
);

  logic [PW-1:0] delta;

  // Select the step size: sign-extended branch offset or plain +1.
  always_comb begin
    delta = PW'(1);
    if (branch) delta = PW'($signed(offset));
  end

  // Advance only when the controller commits an instruction.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      pc <= '0;
    end else if (step) begin
      pc <= pc + delta;
    end
  end

endmodule

// File: rtl/picomips_ctrl.sv
// picoMIPS control unit: Moore FSM sequencing fetch/decode/execute/writeback,
// holding the instruction latch and steering the program counter.
module picomips_ctrl
  import picomips_pkg::*;
#(
  parameter int unsigned PW = 8,
  parameter int unsigned IW = 17
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          run,
  output logic          imem_req,
  input  logic          imem_ack,
  input  logic [IW-1:0] instr,
  output logic [PW-1:0] pc,
  output logic [2:0]    func,
  output logic [2:0]    rd_addr,
  output logic [2:0]    rs_addr,
  output logic [7:0]    imm,
  output logic          imm_sel,
  input  logic          flag,
  output logic          reg_we,
  output logic          br_taken,
  output logic          busy
);

  state_e        state_q;
  logic [IW-1:0] ir_q;
  logic          imem_req_q;
  logic          reg_we_q;
  logic          br_taken_q;
  logic          busy_q;
  logic [2:0]    op;
  logic          taken;

  // Field decode straight from the latch keeps them stable DECODE..WB.
  always_comb begin
    op      = ir_q[OpHi:OpLo];
    rd_addr = ir_q[RdHi:RdLo];
    rs_addr = ir_q[RsHi:RsLo];
    imm     = ir_q[ImmHi:ImmLo];
    func    = alu_func(op);
    imm_sel = uses_imm(op);
    taken   = ((op == RBEQ) && flag) || ((op == RBNE) && !flag);
  end

  // Controller FSM with registered control outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      reg_we_q   <= 1'b0;
      br_taken_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      reg_we_q   <= 1'b0;
      br_taken_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_ack) begin
            ir_q       <= instr;
            state_q    <= StDecode;
            imem_req_q <= 1'b0;
          end
        end
        StDecode: state_q <= StExec;
        StExec: begin
          if (op == RMUL) begin
            state_q <= StExec2;
          end else begin
            // Branches resolve here: flag is sampled on the EXEC->WB edge.
            state_q    <= StWb;
            reg_we_q   <= writes_reg(op);
            br_taken_q <= taken;
          end
        end
        StExec2: begin
          state_q  <= StWb;
          reg_we_q <= writes_reg(op);
        end
        StWb: begin
          if (run) begin
            state_q    <= StFetch;
            imem_req_q <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req = imem_req_q;
  assign reg_we   = reg_we_q;
  assign br_taken = br_taken_q;
  assign busy     = busy_q;

  // pc commits on the edge leaving WB; br_taken_q is high exactly in a taken WB.
  pc_reg #(
    .PW(PW)
  ) u_pc_reg (
    .clk   (clk),
    .nReset(nReset),
    .step  (state_q == StWb),
    .branch(br_taken_q),
    .offset(imm),
    .pc    (pc)
  );

endmodule

// File: tb/tb_picomips_ctrl.sv
// Self-checking bench for picomips_ctrl: directed scenarios plus a random
// instruction stream, checked against an instruction-level reference model.
module tb_picomips_ctrl;
  import picomips_pkg::*;

  logic        clk;
  logic        nReset;
  logic        run;
  logic        imem_req;
  logic        imem_ack;
  logic [16:0] instr;
  logic [7:0]  pc;
  logic [2:0]  func;
  logic [2:0]  rd_addr;
  logic [2:0]  rs_addr;
  logic [7:0]  imm;
  logic        imm_sel;
  logic        flag;
  logic        reg_we;
  logic        br_taken;
  logic        busy;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  pc_exp;

  picomips_ctrl #(
    .PW(8),
    .IW(17)
  ) dut (
    .clk     (clk),
    .nReset  (nReset),
    .run     (run),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .instr   (instr),
    .pc      (pc),
    .func    (func),
    .rd_addr (rd_addr),
    .rs_addr (rs_addr),
    .imm     (imm),
    .imm_sel (imm_sel),
    .flag    (flag),
    .reg_we  (reg_we),
    .br_taken(br_taken),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Asynchronous reset pulse; leaves run low and the model at pc=0.
  task automatic do_reset();
    @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    tests++;
    if ({pc, imem_req, reg_we, br_taken, busy, func, imm_sel, rd_addr, rs_addr, imm} !== '0) begin
      fails++;
      $display("FAIL async_reset: pc=%h req=%b we=%b br=%b busy=%b func=%h isel=%b rd=%h rs=%h imm=%h want all 0",
               pc, imem_req, reg_we, br_taken, busy, func, imm_sel, rd_addr, rs_addr, imm);
    end
    run = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    nReset = 1'b1;
    pc_exp = 8'h00;
  endtask

  // From IDLE: raise run, expect FETCH on the next cycle.
  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b1 || busy !== 1'b1 || pc !== pc_exp) begin
      fails++;
      $display("FAIL start_run: req=%b busy=%b pc=%h want req=1 busy=1 pc=%h",
               imem_req, busy, pc, pc_exp);
    end
  endtask

  // Execute one instruction from FETCH and check every cycle through WB.
  // Precondition and postcondition: at a falling edge, DUT in FETCH.
  task automatic exec_instr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                            input logic [7:0] iv, input int dly, input bit fl,
                            input bit run_after, input bit stray);
    logic [2:0] fexp;
    bit         taken;
    bit         wr;
    bit         isel;
    int         wb_off;
    taken  = (op == RBEQ && fl) || (op == RBNE && !fl);
    wr     = op inside {RLD, RADD, RADDI, RMUL};
    isel   = op inside {RADDI, RLD};
    fexp   = (op inside {RADD, RADDI, RMUL, RLD, RBEQ, RBNE}) ? op : RADD;
    wb_off = (op == RMUL) ? 4 : 3;

    for (int i = 0; i < dly; i++) begin
      imem_ack = 1'b0;
      instr = 17'($urandom);
      tests++;
      if (imem_req !== 1'b1 || busy !== 1'b1 || pc !== pc_exp) begin
        fails++;
        $display("FAIL fetch_wait: req=%b busy=%b pc=%h want req=1 busy=1 pc=%h",
                 imem_req, busy, pc, pc_exp);
      end
      @(negedge clk);
    end
    tests++;
    if (imem_req !== 1'b1) begin
      fails++;
      $display("FAIL fetch_req: req=%b want 1", imem_req);
    end
    imem_ack = 1'b1;
    instr = {op, rd, rs, iv};
    flag = 1'($urandom);

    for (int c = 1; c <= wb_off; c++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      flag = 1'($urandom);
      if (stray && c == 1) begin
        imem_ack = 1'b1;
        instr = 17'($urandom);
      end
      if (c == 2) flag = fl;
      if (c == wb_off) run = run_after;
      tests++;
      if (imem_req !== 1'b0 || busy !== 1'b1 || func !== fexp || rd_addr !== rd ||
          rs_addr !== rs || imm !== iv || imm_sel !== isel || pc !== pc_exp) begin
        fails++;
        $display("FAIL fields c%0d: req=%b busy=%b func=%h rd=%h rs=%h imm=%h isel=%b pc=%h want 0 1 %h %h %h %h %b %h",
                 c, imem_req, busy, func, rd_addr, rs_addr, imm, imm_sel, pc,
                 fexp, rd, rs, iv, isel, pc_exp);
      end
      tests++;
      if (reg_we !== (c == wb_off && wr) || br_taken !== (c == wb_off && taken)) begin
        fails++;
        $display("FAIL pulses c%0d op=%0d: we=%b br=%b want we=%b br=%b",
                 c, op, reg_we, br_taken, (c == wb_off && wr), (c == wb_off && taken));
      end
    end

    pc_exp = 8'(int'(pc_exp) + (taken ? int'($signed(iv)) : 1));
    @(negedge clk);
    imem_ack = 1'b0;
    tests++;
    if (pc !== pc_exp || reg_we !== 1'b0 || br_taken !== 1'b0 ||
        busy !== run_after || imem_req !== run_after) begin
      fails++;
      $display("FAIL after_wb op=%0d: pc=%h we=%b br=%b busy=%b req=%b want pc=%h 0 0 %b %b",
               op, pc, reg_we, br_taken, busy, imem_req, pc_exp, run_after, run_after);
    end
    if (!run_after) start_run();
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    instr = '0;
    flag = 1'b0;
    do_reset();
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b0 || busy !== 1'b0 || pc !== 8'h00) begin
        fails++;
        $display("FAIL idle_hold: req=%b busy=%b pc=%h want 0 0 00", imem_req, busy, pc);
      end
    end
    start_run();
  endtask

  task automatic test_radd();
    exec_instr(RADD, 3'd1, 3'd2, 8'h00, 3, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_branch();
    repeat (4) exec_instr(RADD, 3'd0, 3'd0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    exec_instr(RBEQ, 3'd0, 3'd0, 8'hFC, 1, 1'b1, 1'b1, 1'b0);
    repeat (4) exec_instr(RADD, 3'd0, 3'd0, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    exec_instr(RBEQ, 3'd0, 3'd0, 8'hFC, 0, 1'b0, 1'b1, 1'b0);
    exec_instr(RBNE, 3'd3, 3'd4, 8'h10, 2, 1'b1, 1'b1, 1'b0);
    exec_instr(RBNE, 3'd3, 3'd4, 8'h10, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    exec_instr(RBEQ, 3'd0, 3'd0, 8'(8'hFF - pc_exp), 0, 1'b1, 1'b1, 1'b0);
    exec_instr(RADDI, 3'd5, 3'd6, 8'h0C, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_rmul_nop();
    exec_instr(RMUL, 3'd7, 3'd1, 8'h33, 2, 1'b1, 1'b1, 1'b0);
    exec_instr(RLD, 3'd2, 3'd5, 8'hA5, 0, 1'b0, 1'b0, 1'b0);
    exec_instr(3'd6, 3'd1, 3'd1, 8'h80, 0, 1'b1, 1'b1, 1'b0);
    exec_instr(3'd7, 3'd2, 3'd3, 8'h7F, 1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_stray_ack();
    exec_instr(RADD, 3'd4, 3'd2, 8'h11, 0, 1'b0, 1'b1, 1'b1);
    exec_instr(RBEQ, 3'd1, 3'd6, 8'h04, 1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      exec_instr(3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    start_run();
    repeat (3) exec_instr(RADD, 3'd1, 3'd1, 8'h00, 0, 1'b0, 1'b1, 1'b0);
    tests++;
    if (pc !== 8'h03) begin
      fails++;
      $display("FAIL abort_setup_pc: pc=%h want 03", pc);
    end
    imem_ack = 1'b1;
    instr = {RADD, 3'd1, 3'd2, 8'h00};
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    // DUT now in EXEC of RADD; reset mid-instruction.
    #2 nReset = 1'b0;
    #1;
    tests++;
    if (pc !== 8'h00 || busy !== 1'b0 || reg_we !== 1'b0 || imem_req !== 1'b0 ||
        func !== 3'd0 || rd_addr !== 3'd0 || rs_addr !== 3'd0) begin
      fails++;
      $display("FAIL abort_async: pc=%h busy=%b we=%b req=%b func=%h rd=%h rs=%h want all 0",
               pc, busy, reg_we, imem_req, func, rd_addr, rs_addr);
    end
    run = 1'b0;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (reg_we !== 1'b0 || pc !== 8'h00) begin
        fails++;
        $display("FAIL abort_hold: we=%b pc=%h want 0 00", reg_we, pc);
      end
    end
    nReset = 1'b1;
    pc_exp = 8'h00;
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || imem_req !== 1'b0 || reg_we !== 1'b0) begin
        fails++;
        $display("FAIL abort_idle: busy=%b req=%b we=%b want 0 0 0", busy, imem_req, reg_we);
      end
    end
    start_run();
    exec_instr(RADDI, 3'd2, 3'd3, 8'h09, 1, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    nReset = 1'b0;
    run = 1'b0;
    imem_ack = 1'b0;
    instr = '0;
    flag = 1'b0;
    pc_exp = 8'h00;
    test_reset();
    test_radd();
    test_branch();
    test_wrap();
    test_rmul_nop();
    test_stray_ack();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/picomips_ctrl.md
PICOMIPS_CTRL -- requirements
Module: picomips_ctrl

Interface
REQ-001 Parameter PW, default 8: program counter width.
REQ-002 Parameter IW, default 17: instruction width, fields op[16:14], rd[13:11], rs[10:8], imm[7:0].
REQ-003 clk  input  1  system clock, rising-edge active.
REQ-004 nReset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; start fetching from IDLE, sampled each cycle.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_ack  input  1  memory has placed instruction on instr this cycle.
REQ-008 instr  input  IW  instruction word, valid when imem_ack=1.
REQ-009 pc  output  PW  current program counter.
REQ-010 func  output  3  ALU function code, drawn from the shared alucodes set.
REQ-011 rd_addr, rs_addr  output  3 each  register file addresses.
REQ-012 imm  output  8  immediate field of the latched instruction.
REQ-013 imm_sel  output  1  ALU operand b takes imm instead of register data.
REQ-014 flag  input  1  ALU flag, sampled in EXEC.
REQ-015 reg_we  output  1  register file write enable, one-cycle pulse.
REQ-016 br_taken  output  1  one-cycle pulse when a branch is taken.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The controller SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC, EXEC2 and WB.
- IDLE: stay while run=0; run=1 -> FETCH.
- FETCH: imem_req=1, held until imem_ack=1; the ack edge latches instr -> DECODE.
- DECODE: rd_addr, rs_addr, imm, func and imm_sel driven from the latch -> EXEC.
- EXEC: RMUL -> EXEC2; all other opcodes -> WB.
- EXEC2: -> WB.
- WB: reg_we/pc update; run=1 -> FETCH, run=0 -> IDLE.
REQ-019 func, rd_addr, rs_addr, imm and imm_sel SHALL come from the instruction latch and stay stable from DECODE through WB.
REQ-020 imm_sel SHALL be 1 only for RADDI and RLD.
REQ-021 reg_we SHALL be 1 in WB only, and only for RLD, RADD, RADDI and RMUL.
REQ-022 Branch resolution SHALL sample flag in the last EXEC cycle. RBEQ is taken when flag=1; RBNE is taken when flag=0.
REQ-023 In WB the pc update SHALL be:
- taken branch: pc <= pc + sign-extended imm;
- otherwise: pc <= pc + 1.
REQ-024 pc arithmetic SHALL be modulo 2^PW; wrap-around is silent.
REQ-025 br_taken SHALL be 1 in WB of a taken branch only.
REQ-026 An opcode outside the six defined codes SHALL execute as a NOP: func=RADD, reg_we=0, pc+1.
REQ-027 imem_ack SHALL be ignored outside FETCH.
REQ-028 Latency: an ack in cycle k SHALL give WB in cycle k+3, or k+4 for RMUL.

Reset
REQ-029 nReset=0 SHALL, asynchronously and in any state, force the following outputs to 0: IDLE, pc, instr latch, imem_req, reg_we, br_taken, busy, func, imm_sel, rd_addr, rs_addr, imm.
REQ-030 Reset asserted mid-instruction SHALL abort it with no reg_we pulse and no pc change.
REQ-031 Reset release SHALL be followed by IDLE; fetch begins on the first clock edge with run=1.

Structure
REQ-032 The shared package picomips_pkg SHALL hold:
- the state enum;
- the field position constants;
- the opcode values, identical to the alucodes function codes.
REQ-033 The FSM and datapath (pc, instruction latch) SHALL reside in the single module; sub-module pc_reg (PW-wide, load/increment/offset) is permitted.

Verification
REQ-034 Reset, then run=1 -> imem_req=1 on the next cycle, pc=0, busy=1.
REQ-035 Fetch RADD rd=1 rs=2 with ack after 3 cycles -> imem_req held 3 cycles; func=RADD, imm_sel=0; a single reg_we pulse in WB; pc=1.
REQ-036 At pc=5, RBEQ imm=8'hFC with flag=1 -> br_taken pulse, pc=1, no reg_we.
- Same instruction with flag=0 -> pc=6.
REQ-037 At pc=8'hFF, RADDI imm=8'h0C -> imm_sel=1, reg_we pulse, pc wraps to 8'h00.
REQ-038 RMUL -> EXEC lasts 2 cycles, WB at ack+4, reg_we pulse once.
- RBNE with flag=1 -> pc+1, br_taken=0.
REQ-039 nReset=0 during EXEC of RADD at pc=3 -> no reg_we pulse, pc=0, IDLE.
- Stray imem_ack in DECODE -> no effect.
